// File: rtl/sync_clk_supervisor_if.sv
// Sync-clock link between the supervisor (external end) and the counter block.
interface SyncClkInterface #(
   parameter int COUNTER_SIZE = 19
);
   logic                    resetCyclic;
   logic                    clearError;
   logic [COUNTER_SIZE-1:0] syncCounter;
   logic                    errorFlag;

   modport external (
      output resetCyclic,
      output clearError,
      input  syncCounter,
      input  errorFlag
   );

   modport internal (
      input  resetCyclic,
      input  clearError,
      output syncCounter,
      output errorFlag
   );
endinterface

// File: rtl/sync_clk_supervisor.sv
// Sync-clock supervisor: periodic cyclic reset, counter snapshot with window
// and lock check, and a timed request/acknowledge clear of the sync error.
module sync_clk_supervisor #(
   parameter int COUNTER_SIZE   = 19,
   parameter int PERIOD         = 1000,
   parameter int EXPECTED_COUNT = 999,
   parameter int TOLERANCE      = 2,
   parameter int LOCK_COUNT     = 4,
   parameter int CLEAR_TIMEOUT  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    clearRequest,
   SyncClkInterface.external       syncIf,
   output logic [COUNTER_SIZE-1:0] capturedCount,
   output logic                    captureValid,
   output logic                    locked,
   output logic                    errorLatched,
   output logic [7:0]              errorCount,
   output logic                    clearTimeout
);

   localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int RW = $clog2(LOCK_COUNT + 1);
   localparam int TW = $clog2(CLEAR_TIMEOUT + 1);
   localparam int HI_I = EXPECTED_COUNT + TOLERANCE;
   localparam int LO_I = (EXPECTED_COUNT > TOLERANCE) ? (EXPECTED_COUNT - TOLERANCE) : 0;

   localparam logic [PW-1:0]         PERIOD_LAST = PW'(PERIOD - 1);
   localparam logic [RW-1:0]         RUN_MAX     = RW'(LOCK_COUNT);
   localparam logic [TW-1:0]         TMO_LAST    = TW'(CLEAR_TIMEOUT - 1);
   localparam logic [COUNTER_SIZE:0] WIN_HI      = (COUNTER_SIZE + 1)'(HI_I);
   localparam logic [COUNTER_SIZE:0] WIN_LO      = (COUNTER_SIZE + 1)'(LO_I);

   typedef enum logic [1:0] {
      NORMAL   = 2'd0,
      FAULT    = 2'd1,
      CLEARING = 2'd2
   } err_state_e;

   logic [PW-1:0]           period_q, period_d;
   logic                    rc_q, rc_d;
   logic                    armed_q, armed_d;
   logic [COUNTER_SIZE-1:0] captured_q, captured_d;
   logic                    capv_q, capv_d;
   logic [RW-1:0]           run_q, run_d;
   logic                    locked_q, locked_d;

   err_state_e              state_q, state_d;
   logic                    clr_q, clr_d;
   logic                    latched_q, latched_d;
   logic [7:0]              ecount_q, ecount_d;
   logic [TW-1:0]           tmo_q, tmo_d;
   logic                    ctmo_q, ctmo_d;
   logic                    prev_q, prev_d;

   logic [COUNTER_SIZE:0]   sample_ext;
   logic                    in_win;
   logic                    rise;

   assign sample_ext = {1'b0, syncIf.syncCounter};
   assign in_win     = (sample_ext >= WIN_LO) && (sample_ext <= WIN_HI);
   assign rise       = syncIf.errorFlag && !prev_q;

   // Period counter, cyclic reset pulse, snapshot and lock run tracking.
   always_comb begin
      period_d   = '0;
      rc_d       = 1'b0;
      armed_d    = 1'b0;
      captured_d = captured_q;
      capv_d     = 1'b0;
      run_d      = '0;
      if (enable) begin
         period_d = (period_q == PERIOD_LAST) ? '0 : period_q + 1'b1;
         rc_d     = (period_q == PERIOD_LAST);
         // The first pulse after enable only arms capture; it is never checked.
         armed_d  = armed_q | rc_q;
         run_d    = run_q;
         if (rc_q && armed_q) begin
            captured_d = syncIf.syncCounter;
            capv_d     = 1'b1;
            if (in_win) begin
               run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
            end else begin
               run_d = '0;
            end
         end
      end
      if (syncIf.errorFlag) begin
         run_d = '0;
      end
      locked_d = (run_d == RUN_MAX);
   end

   // Error flag edge detection and clear handshake with timeout.
   always_comb begin
      state_d   = state_q;
      clr_d     = clr_q;
      latched_d = latched_q;
      ecount_d  = ecount_q;
      tmo_d     = tmo_q;
      ctmo_d    = ctmo_q;
      prev_d    = syncIf.errorFlag;
      unique case (state_q)
         NORMAL: begin
            if (rise) begin
               state_d   = FAULT;
               latched_d = 1'b1;
               if (ecount_q != '1) begin
                  ecount_d = ecount_q + 8'd1;
               end
            end
         end
         FAULT: begin
            if (clearRequest) begin
               state_d = CLEARING;
               clr_d   = 1'b1;
               tmo_d   = '0;
            end
         end
         CLEARING: begin
            if (!syncIf.errorFlag) begin
               state_d   = NORMAL;
               clr_d     = 1'b0;
               latched_d = 1'b0;
               ctmo_d    = 1'b0;
               prev_d    = 1'b0;
            end else if (tmo_q == TMO_LAST) begin
               state_d = FAULT;
               clr_d   = 1'b0;
               ctmo_d  = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: begin
            state_d = NORMAL;
            clr_d   = 1'b0;
         end
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         period_q   <= '0;
         rc_q       <= 1'b0;
         armed_q    <= 1'b0;
         captured_q <= '0;
         capv_q     <= 1'b0;
         run_q      <= '0;
         locked_q   <= 1'b0;
         state_q    <= NORMAL;
         clr_q      <= 1'b0;
         latched_q  <= 1'b0;
         ecount_q   <= '0;
         tmo_q      <= '0;
         ctmo_q     <= 1'b0;
         prev_q     <= 1'b0;
      end else begin
         period_q   <= period_d;
         rc_q       <= rc_d;
         armed_q    <= armed_d;
         captured_q <= captured_d;
         capv_q     <= capv_d;
         run_q      <= run_d;
         locked_q   <= locked_d;
         state_q    <= state_d;
         clr_q      <= clr_d;
         latched_q  <= latched_d;
         ecount_q   <= ecount_d;
         tmo_q      <= tmo_d;
         ctmo_q     <= ctmo_d;
         prev_q     <= prev_d;
      end
   end

   assign syncIf.resetCyclic = rc_q;
   assign syncIf.clearError  = clr_q;
   assign capturedCount      = captured_q;
   assign captureValid       = capv_q;
   assign locked             = locked_q;
   assign errorLatched       = latched_q;
   assign errorCount         = ecount_q;
   assign clearTimeout       = ctmo_q;

endmodule

// File: doc/sync_clk_supervisor.md
Name: sync_clk_supervisor

Overview:
- Controller end of the sync-clock link: drives resetCyclic and clearError, consumes syncCounter and errorFlag.
- Generates the periodic cyclic reset and snapshots syncCounter at each reset.
- Checks each snapshot against an expected window and reports lock.
- Runs a request/acknowledge clear handshake, with timeout, on the sync error flag.
- Sits between the register bank (enable, clearRequest, status) and the sync-clock counter block.

Parameters:
- COUNTER_SIZE, 19, width of syncCounter and capturedCount.
- PERIOD, 1000, clk cycles between resetCyclic pulses (≥2).
- EXPECTED_COUNT, 999, nominal syncCounter value at resetCyclic.
- TOLERANCE, 2, inclusive ± window around EXPECTED_COUNT.
- LOCK_COUNT, 4, consecutive in-window captures required to assert locked.
- CLEAR_TIMEOUT, 16, max clk cycles clearError is held waiting for errorFlag to fall.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  run cyclic reset generation and window checking
- clearRequest  in  1  one-cycle host request to clear sync error
- syncIf  SyncClkInterface.external  —  drives resetCyclic, clearError; reads syncCounter[COUNTER_SIZE-1:0], errorFlag
- capturedCount  out  COUNTER_SIZE  last syncCounter snapshot
- captureValid  out  1  one-cycle pulse when capturedCount updated
- locked  out  1  LOCK_COUNT consecutive in-window captures and no error
- errorLatched  out  1  sync error pending clear
- errorCount  out  8  saturating count of errorFlag rising edges
- clearTimeout  out  1  sticky: last clear attempt timed out

Behaviour:
- Reset (synchronous, active-high): all outputs 0, including resetCyclic and clearError. Internal counters 0. Error FSM enters NORMAL. Sampled errorFlag history = 0. Reset asserted mid-operation aborts everything at that edge.
- Period counter:
  - enable=1: increments 0..PERIOD-1 and wraps.
  - resetCyclic is registered and high for exactly one cycle, the cycle after the counter equals PERIOD-1. Pulse spacing is exactly PERIOD cycles.
  - enable=0: counter held at 0, resetCyclic 0, lock run count 0, locked 0.
- Capture:
  - syncCounter is sampled in the cycle resetCyclic=1.
  - Next cycle: capturedCount updates and captureValid pulses (latency 1).
  - The first resetCyclic after enable rises is not captured: no captureValid, no check.
- Window check (on captureValid):
  - in-window iff lo ≤ capturedCount ≤ hi.
  - hi = EXPECTED_COUNT+TOLERANCE, computed at COUNTER_SIZE+1 bits.
  - lo = max(0, EXPECTED_COUNT−TOLERANCE); no underflow.
  - In-window: run count increments, saturating at LOCK_COUNT. locked=1 in the cycle run count reaches LOCK_COUNT.
  - Out-of-window: run count 0 and locked 0 in that same cycle.
  - errorFlag=1 forces locked=0 and run count=0.
- Error FSM:
  - NORMAL: a rising edge on errorFlag (registered previous value 0, current 1) moves to FAULT. errorLatched←1, errorCount+1 (saturating at 255). clearRequest is ignored in NORMAL, including when it coincides with a rising edge.
  - FAULT: clearRequest moves to CLEARING with clearError←1.
  - CLEARING: clearError held high; timeout counter counts from 0.
    - errorFlag=0 sampled: next cycle → NORMAL, clearError 0, errorLatched 0, clearTimeout 0.
    - Timeout counter reaches CLEAR_TIMEOUT with errorFlag still 1: → FAULT, clearError 0, clearTimeout←1. errorLatched stays 1.
    - clearRequest in FAULT or CLEARING while already clearing: ignored.
  - Returning to NORMAL clears the edge history, so errorFlag re-rising later counts again.
- Independence: resetCyclic and clearError may be high in the same cycle. Error FSM, errorCount and clearTimeout operate regardless of enable.
- errorCount cleared only by reset.

Test Plan:
- Reset, enable=1, syncCounter model counts clocks and resets on resetCyclic → resetCyclic pulses every 1000 cycles. First pulse has no captureValid. Subsequent captureValid show capturedCount=999. locked=1 on the 4th valid capture.
- Locked state, force syncCounter to 1003 at one capture → locked=0 and run count 0 that cycle. Four more captures of 999 → locked=1 again. Capture 997 counts as in-window.
- errorFlag rises while locked → locked=0, errorLatched=1, errorCount=1. clearRequest → clearError=1. Drop errorFlag 5 cycles later → next cycle clearError=0, errorLatched=0.
- Fault, clearRequest, errorFlag held high → clearError high 16 cycles then 0, clearTimeout=1, state FAULT. Second clearRequest with errorFlag falling → clearTimeout=0.
- 300 errorFlag pulses each followed by a successful clear → errorCount saturates at 255.
- Assert reset during CLEARING with enable=1 → next edge: clearError=0, resetCyclic=0, all status 0. After release, first resetCyclic arrives PERIOD cycles later.
